ram_arbiter: RTL and testbench

- Arbitrates the single-port data RAM between two requesters: port 0 (control unit load/store path) and port 1 (external I/O / debug loader).
- Sits between the requesters and the RAM instance, and owns the RAM's we/addr/in pins exclusively.
- One access per grant; round-robin arbitration on contention; fixed, cycle-exact latency.

---
 rtl/ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous-read RAM.
// One access per grant: write = IDLE->ACCESS, read = IDLE->ACCESS->RESP.
module ram_arbiter #(
    parameter int unsigned RAM_SIZE = 2,
    parameter int unsigned DATA_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [RAM_SIZE-1:0] m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [RAM_SIZE-1:0] m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                ram_we,
    output logic [RAM_SIZE-1:0] ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic owner_q, owner_d;
    logic last_grant_q, last_grant_d;
    logic we_q, we_d;
    logic sel;

    // Registered copies of outputs, loaded from next-state decode
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic                ram_we_q, ram_we_d;
    logic [RAM_SIZE-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    // State, arbitration bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            busy_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            busy_q       <= busy_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Next state, arbitration, and next values of the registered outputs
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        sel          = 1'b0;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = '0;
        ram_wdata_d  = '0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie the port that was not granted last wins
                    sel         = (m0_req && m1_req) ? ~last_grant_q : m1_req;
                    owner_d     = sel;
                    we_d        = sel ? m1_we : m0_we;
                    ram_we_d    = sel ? m1_we : m0_we;
                    ram_addr_d  = sel ? m1_addr : m0_addr;
                    ram_wdata_d = sel ? m1_wdata : m0_wdata;
                    gnt0_d      = ~sel;
                    gnt1_d      = sel;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                last_grant_d = owner_q;
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    rvalid0_d = ~owner_q;
                    rvalid1_d = owner_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (owner_q) rdata1_d = ram_rdata;
                else         rdata0_d = ram_rdata;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign m0_gnt    = gnt0_q;
    assign m1_gnt    = gnt1_q;
    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;

    // RAM data arrives in the RESP cycle itself, so the owner sees it passed through
    assign m0_rdata = rvalid0_q ? ram_rdata : rdata0_q;
    assign m1_rdata = rvalid1_q ? ram_rdata : rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural synchronous-read RAM.
module tb_ram_arbiter;

    localparam int unsigned RAM_SIZE = 2;
    localparam int unsigned DATA_W   = 16;

    typedef struct {
        bit                  port;
        bit                  we;
        logic [RAM_SIZE-1:0] addr;
        logic [DATA_W-1:0]   wdata;
        int                  cyc;
    } gnt_exp_t;

    typedef struct {
        bit                port;
        logic [DATA_W-1:0] data;
        int                cyc;
    } rv_exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                m0_req = 1'b0, m0_we = 1'b0;
    logic [RAM_SIZE-1:0] m0_addr = '0;
    logic [DATA_W-1:0]   m0_wdata = '0;
    logic                m0_gnt, m0_rvalid;
    logic [DATA_W-1:0]   m0_rdata;
    logic                m1_req = 1'b0, m1_we = 1'b0;
    logic [RAM_SIZE-1:0] m1_addr = '0;
    logic [DATA_W-1:0]   m1_wdata = '0;
    logic                m1_gnt, m1_rvalid;
    logic [DATA_W-1:0]   m1_rdata;
    logic                ram_we;
    logic [RAM_SIZE-1:0] ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata = '0;
    logic                busy;

    logic [DATA_W-1:0] mem [4] = '{16'h0A0A, 16'h1111, 16'h2222, 16'h3333};
    logic [DATA_W-1:0] last_rd [2] = '{16'h0000, 16'h0000};

    gnt_exp_t gq[$];
    rv_exp_t  rq[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    ram_arbiter #(.RAM_SIZE(RAM_SIZE), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data for the presented address appears the following cycle
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_gnt(input bit port, input bit we, input logic [RAM_SIZE-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input int c);
        gnt_exp_t e;
        e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.cyc = c;
        gq.push_back(e);
    endtask

    task automatic push_rv(input bit port, input logic [DATA_W-1:0] data, input int c);
        rv_exp_t e;
        e.port = port; e.data = data; e.cyc = c;
        rq.push_back(e);
    endtask

    // Monitor: pops expectations whenever the DUT shows a grant or read response
    always @(negedge clk) begin
        if (mon_en) begin
            gnt_exp_t g;
            rv_exp_t  r;
            chk("gnt_exclusive", 32'(m0_gnt & m1_gnt), 32'd0);
            chk("rvalid_exclusive", 32'(m0_rvalid & m1_rvalid), 32'd0);
            if (m0_gnt || m1_gnt) begin
                chk("gnt_expected", 32'(gq.size() != 0), 32'd1);
                if (gq.size() != 0) begin
                    g = gq.pop_front();
                    chk("gnt_port", 32'(m1_gnt), 32'(g.port));
                    chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
                    chk("gnt_ram_we", 32'(ram_we), 32'(g.we));
                    chk("gnt_ram_addr", 32'(ram_addr), 32'(g.addr));
                    chk("gnt_ram_wdata", 32'(ram_wdata), 32'(g.wdata));
                end
            end else begin
                chk("idle_bus", {15'd0, ram_we, 14'd0, ram_addr}, 32'd0);
                chk("idle_wdata", 32'(ram_wdata), 32'd0);
            end
            if (m0_rvalid || m1_rvalid) begin
                chk("rvalid_expected", 32'(rq.size() != 0), 32'd1);
                if (rq.size() != 0) begin
                    r = rq.pop_front();
                    chk("rvalid_port", 32'(m1_rvalid), 32'(r.port));
                    chk("rvalid_cycle", 32'(cyc), 32'(r.cyc));
                    if (r.port) begin
                        chk("m1_rdata", 32'(m1_rdata), 32'(r.data));
                        chk("m0_rdata_hold", 32'(m0_rdata), 32'(last_rd[0]));
                        last_rd[1] = r.data;
                    end else begin
                        chk("m0_rdata", 32'(m0_rdata), 32'(r.data));
                        chk("m1_rdata_hold", 32'(m1_rdata), 32'(last_rd[1]));
                        last_rd[0] = r.data;
                    end
                end
            end
        end
    end

    // Directed stimulus with hand-computed expected grant/response cycles
    initial begin
        int t;

        // Reset held with both requesters asking for reads
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 2'd1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 2'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
            chk("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
            chk("rst_ram_we_busy", {30'd0, ram_we, busy}, 32'd0);
            chk("rst_ram_addr", 32'(ram_addr), 32'd0);
            chk("rst_rdata", {m0_rdata, m1_rdata}, 32'd0);
        end
        mon_en = 1'b1;

        // Continuous contention: port 0 first, then strict alternation
        rst = 1'b1;
        t = cyc;
        push_gnt(0, 0, 2'd1, 16'h0000, t + 1);  push_rv(0, 16'h1111, t + 2);
        push_gnt(1, 0, 2'd3, 16'h0000, t + 4);  push_rv(1, 16'h3333, t + 5);
        push_gnt(0, 0, 2'd1, 16'h0000, t + 7);  push_rv(0, 16'h1111, t + 8);
        push_gnt(1, 0, 2'd3, 16'h0000, t + 10); push_rv(1, 16'h3333, t + 11);
        push_gnt(0, 0, 2'd1, 16'h0000, t + 13); push_rv(0, 16'h1111, t + 14);
        push_gnt(1, 0, 2'd3, 16'h0000, t + 16); push_rv(1, 16'h3333, t + 17);
        repeat (16) tick();
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) tick();

        // Port 0 writes BEEF to address 2, then port 1 reads it back
        t = cyc;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 2'd2; m0_wdata = 16'hBEEF;
        push_gnt(0, 1, 2'd2, 16'hBEEF, t + 1);
        tick();
        m0_req = 1'b0;
        tick();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 2'd2; m1_wdata = 16'h0000;
        push_gnt(1, 0, 2'd2, 16'h0000, t + 3);
        push_rv(1, 16'hBEEF, t + 4);
        tick();
        m1_req = 1'b0;
        repeat (2) tick();

        // Lone port 1 writer served every two cycles
        m1_req = 1'b1; m1_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m1_addr  = 2'(i);
            m1_wdata = 16'hA000 + 16'(i);
            push_gnt(1, 1, 2'(i), 16'hA000 + 16'(i), cyc + 1);
            tick();
            if (i == 3) m1_req = 1'b0;
            tick();
        end
        chk("lone_mem0", 32'(mem[0]), 32'h0000A000);
        chk("lone_mem1", 32'(mem[1]), 32'h0000A001);
        chk("lone_mem2", 32'(mem[2]), 32'h0000A002);
        chk("lone_mem3", 32'(mem[3]), 32'h0000A003);

        // Held request is served twice; dropped-on-grant request once
        t = cyc;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 2'd1; m0_wdata = 16'h5A5A;
        push_gnt(0, 1, 2'd1, 16'h5A5A, t + 1);
        push_gnt(0, 1, 2'd1, 16'h5A5A, t + 3);
        repeat (3) tick();
        m0_req = 1'b0;
        tick();
        m0_req = 1'b1; m0_addr = 2'd0; m0_wdata = 16'h7777;
        push_gnt(0, 1, 2'd0, 16'h7777, cyc + 1);
        tick();
        m0_req = 1'b0; m0_addr = 2'd3; m0_wdata = 16'hFFFF;
        repeat (2) tick();
        chk("held_mem1", 32'(mem[1]), 32'h00005A5A);
        chk("single_mem0", 32'(mem[0]), 32'h00007777);

        // Reset asserted during the RESP cycle of a port 0 read
        t = cyc;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 2'd2; m0_wdata = 16'h0000;
        push_gnt(0, 0, 2'd2, 16'h0000, t + 1);
        push_rv(0, 16'hA002, t + 2);
        tick();
        m0_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rdata", 32'(m0_rdata), 32'd0);
        rst = 1'b1;
        repeat (3) tick();
        chk("midrst_busy_after", 32'(busy), 32'd0);

        chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
        chk("rvalid_queue_drained", 32'(rq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
